qupls_regs_expander: RTL and testbench
======================================

QUPLS_REGS_EXPANDER -- requirements
Module: Qupls_regs_expander

Interface
REQ-001 SHALL have parameter MASK_W, default 16, register-mask width.
REQ-002 SHALL have parameter OFS_STEP, default 8, byte offset step per transferred register.
REQ-003 SHALL have ports: rst_n  input  1  asynchronous active-low reset; clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: flush  input  1  abort current sequence; in_valid  input  1  REGS instruction offered; in_ready  output  1  expander can accept.
REQ-005 SHALL have port instr  input  instruction_t  instruction word; OP_REGS fields decoded via regs_instr_t.
REQ-006 SHALL have ports: uop_valid  output  1; uop_ready  input  1; uop_reg  output  6  architectural register; uop_ofs  output  16  byte offset from base.
REQ-007 SHALL have ports: uop_load  output  1  1=load, 0=store; uop_base  output  6  base-address register; uop_last  output  1  final micro-op of sequence.

Function
REQ-008 SHALL implement states IDLE and RUN only.
REQ-009 in_ready SHALL be 1 in IDLE, 0 in RUN.
REQ-010 Handshake in IDLE: instruction accepted when in_valid && in_ready && instr opcode == OP_REGS; non-REGS opcodes are accepted and dropped.
REQ-011 On accept with non-zero mask: latch mask, group (2 bits, selecting register block group*16), load bit, base reg; clear count; enter RUN next cycle.
REQ-012 On accept with zero mask: no micro-op emitted, remain IDLE.
REQ-013 In RUN, uop_valid SHALL be 1; uop_reg = {group, index of lowest set mask bit}; uop_ofs = count*OFS_STEP, truncated to 16 bits.
REQ-014 uop_last SHALL be 1 when exactly one mask bit remains set.
REQ-015 On uop_valid && uop_ready: clear lowest set bit, increment count; if uop_last, return to IDLE next cycle.
REQ-016 Outputs uop_* SHALL hold stable while uop_valid && !uop_ready.
REQ-017 Throughput: one micro-op per cycle while uop_ready held high; first micro-op appears cycle after accept.
REQ-018 flush SHALL take priority over all events: next state IDLE, mask cleared, no accept that cycle, uop handshake that cycle ignored.
REQ-019 uop_valid SHALL be 0 in IDLE; uop_* data fields SHALL be 0 in IDLE.
REQ-020 Mask 0xFFFF SHALL produce 16 micro-ops, offsets 0..120, last on reg index 15.

Reset
REQ-021 rst_n low SHALL asynchronously force state IDLE, mask 0, count 0, group 0, load 0, base 0.
REQ-022 During and after reset: in_ready 1 (once rst_n high), uop_valid 0, uop_last 0, uop_reg 0, uop_ofs 0, uop_load 0, uop_base 0.
REQ-023 Reset asserted mid-sequence SHALL discard the sequence; no further micro-ops issued.

Structure
REQ-024 regs_instr_t (opcode, mask, group, load, base fields) and OP_REGS SHALL reside in QuplsPkg.
REQ-025 Lowest-set-bit search SHALL be a sub-module Qupls_ffz_lsb (MASK_W input, index and found outputs); all else inline.

Verification
REQ-026 Mask 0x0005, group 1, store, base 30, uop_ready=1 -> two uops: reg 16 ofs 0, reg 18 ofs 8 last; in_ready back 1 the cycle after.
REQ-027 Mask 0xFFFF, load, uop_ready=1 -> 16 consecutive uops, regs 0..15, ofs 0..120 step 8, uop_last only on 16th.
REQ-028 Mask 0x8001, uop_ready low 3 cycles -> reg 0 ofs 0 held stable 3 cycles, then reg 15 ofs 8 last.
REQ-029 Mask 0x00F0, flush on second uop cycle -> uop_valid 0 next cycle, in_ready 1, no reg 6/7 issued.
REQ-030 Mask 0x0000 and non-REGS opcode offered -> in_ready stays 1, uop_valid never asserts.
REQ-031 rst_n low mid-sequence (mask 0x0F00) -> uop_valid 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/qupls_regs_expander_pkg.sv
// Shared types for the REGS multi-register load/store expander: the
// instruction word layout, the REGS opcode, and the expander state encoding.
package qupls_regs_expander_pkg;

   localparam int INSTR_W   = 32;
   localparam int OPCODE_W  = 7;
   localparam int REG_W     = 6;
   localparam int OFS_W     = 16;
   localparam int GROUP_W   = 2;
   localparam int FIELD_MASK_W = 16;

   typedef logic [INSTR_W-1:0] instruction_t;

   localparam logic [OPCODE_W-1:0] OP_REGS = 7'h5A;

   // REGS instruction layout, opcode in the low bits:
   // [31:26] base, [25] load, [24:23] group, [22:7] mask, [6:0] opcode
   typedef struct packed {
      logic [REG_W-1:0]        base;
      logic                    load;
      logic [GROUP_W-1:0]      group;
      logic [FIELD_MASK_W-1:0] mask;
      logic [OPCODE_W-1:0]     opcode;
   } regs_instr_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/qupls_regs_expander_ffz_lsb.sv
// Lowest-set-bit finder: returns the index of the least significant 1 in the
// mask and whether any bit is set at all.
module qupls_regs_expander_ffz_lsb #(
   parameter int MASK_W = 16,
   parameter int IDX_W  = (MASK_W > 1) ? $clog2(MASK_W) : 1
) (
   input  logic [MASK_W-1:0] mask,
   output logic [IDX_W-1:0]  index,
   output logic              found
);

   // Scan from the top down so the last hit written is the lowest set bit.
   always_comb begin
      index = '0;
      found = 1'b0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (mask[i]) begin
            index = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/qupls_regs_expander.sv
// Expands one REGS instruction (register mask + group + base) into a stream
// of single-register load/store micro-ops, lowest register first, one per
// accepted handshake, with byte offsets advancing by OFS_STEP each micro-op.
module qupls_regs_expander
   import qupls_regs_expander_pkg::*;
#(
   parameter int MASK_W   = 16,
   parameter int OFS_STEP = 8
) (
   input  logic               rst_n,
   input  logic               clk,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  instruction_t       instr,
   output logic               uop_valid,
   input  logic               uop_ready,
   output logic [REG_W-1:0]   uop_reg,
   output logic [OFS_W-1:0]   uop_ofs,
   output logic               uop_load,
   output logic [REG_W-1:0]   uop_base,
   output logic               uop_last
);

   localparam int IDX_W = (MASK_W > 1) ? $clog2(MASK_W) : 1;
   localparam int CNT_W = $clog2(MASK_W + 1);

   state_t             state;
   logic [MASK_W-1:0]  mask;
   logic [CNT_W-1:0]   count;
   logic [GROUP_W-1:0] group;
   logic               load;
   logic [REG_W-1:0]   base;

   regs_instr_t        ri;
   logic [MASK_W-1:0]  in_mask;
   logic               is_regs;
   logic               run;
   logic [IDX_W-1:0]   idx;
   logic               found;
   logic [MASK_W-1:0]  mask_clr;
   logic               last_one;
   logic [31:0]        ofs_full;
   logic [REG_W-1:0]   reg_sel;

   assign ri      = regs_instr_t'(instr);
   assign in_mask = MASK_W'(ri.mask);
   assign is_regs = (ri.opcode == OP_REGS);
   assign run     = (state == RUN);

   qupls_regs_expander_ffz_lsb #(
      .MASK_W (MASK_W),
      .IDX_W  (IDX_W)
   ) u_ffz (
      .mask  (mask),
      .index (idx),
      .found (found)
   );

   // Dropping the lowest set bit: x & (x-1).
   assign mask_clr = mask & (mask - MASK_W'(1));
   assign last_one = found && (mask_clr == '0);

   // Offset wraps at 16 bits; register number is group*16 + bit index.
   assign ofs_full = 32'(count) * 32'(OFS_STEP);
   assign reg_sel  = REG_W'({group, 4'b0000}) + REG_W'(idx);

   // Outputs decode registered state only; data fields are forced to zero in IDLE.
   always_comb begin
      in_ready  = !run;
      uop_valid = run;
      uop_reg   = run ? reg_sel : '0;
      uop_ofs   = run ? ofs_full[OFS_W-1:0] : '0;
      uop_load  = run ? load : 1'b0;
      uop_base  = run ? base : '0;
      uop_last  = run && last_one;
   end

   // Sequencer: flush beats everything, IDLE latches a non-empty REGS
   // instruction, RUN retires one mask bit per completed handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         mask  <= '0;
         count <= '0;
         group <= '0;
         load  <= 1'b0;
         base  <= '0;
      end else if (flush) begin
         state <= IDLE;
         mask  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && is_regs && (in_mask != '0)) begin
                  mask  <= in_mask;
                  group <= ri.group;
                  load  <= ri.load;
                  base  <= ri.base;
                  count <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (uop_ready) begin
                  mask  <= mask_clr;
                  count <= count + CNT_W'(1);
                  if (last_one) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qupls_regs_expander.sv
// Directed bench for the REGS expander: reset, short and full masks,
// back-pressure, flush, ignored instructions and reset mid-sequence.
module tb_qupls_regs_expander;
   import qupls_regs_expander_pkg::*;

   logic         rst_n;
   logic         clk;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   instruction_t instr;
   logic         uop_valid;
   logic         uop_ready;
   logic [5:0]   uop_reg;
   logic [15:0]  uop_ofs;
   logic         uop_load;
   logic [5:0]   uop_base;
   logic         uop_last;

   int checks;
   int failures;

   qupls_regs_expander #(.MASK_W(16), .OFS_STEP(8)) dut (
      .rst_n     (rst_n),
      .clk       (clk),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .uop_valid (uop_valid),
      .uop_ready (uop_ready),
      .uop_reg   (uop_reg),
      .uop_ofs   (uop_ofs),
      .uop_load  (uop_load),
      .uop_base  (uop_base),
      .uop_last  (uop_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit layout written out by hand: base, load, group, mask, opcode.
   function automatic logic [31:0] mk(input logic [6:0] op, input logic [15:0] m,
                                      input logic [1:0] g, input logic ld, input logic [5:0] b);
      return {b, ld, g, m, op};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction for a single cycle; returns just after the accepting edge.
   task automatic offer(input logic [31:0] w);
      instr    = w;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      instr    = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; uop_ready = 1'b0;
      step(); step();
      checks++;
      if ({uop_valid, uop_last, uop_load} !== 3'b000 || uop_reg !== 6'd0 ||
          uop_ofs !== 16'd0 || uop_base !== 6'd0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b l=%b ld=%b reg=%0d ofs=%0d base=%0d required all 0",
                  uop_valid, uop_last, uop_load, uop_reg, uop_ofs, uop_base);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || uop_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got in_ready=%b uop_valid=%b required 1/0", in_ready, uop_valid);
      end
   endtask

   task automatic test_two_uops();
      uop_ready = 1'b1;
      offer(mk(OP_REGS, 16'h0005, 2'd1, 1'b0, 6'd30));
      checks++;
      if (uop_valid !== 1'b1 || uop_reg !== 6'd16 || uop_ofs !== 16'd0 || uop_last !== 1'b0 ||
          uop_load !== 1'b0 || uop_base !== 6'd30 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL two_uops_first got v=%b reg=%0d ofs=%0d last=%b ld=%b base=%0d rdy=%b required 1 16 0 0 0 30 0",
                  uop_valid, uop_reg, uop_ofs, uop_last, uop_load, uop_base, in_ready);
      end
      step();
      checks++;
      if (uop_valid !== 1'b1 || uop_reg !== 6'd18 || uop_ofs !== 16'd8 || uop_last !== 1'b1) begin
         failures++;
         $display("FAIL two_uops_second got v=%b reg=%0d ofs=%0d last=%b required 1 18 8 1",
                  uop_valid, uop_reg, uop_ofs, uop_last);
      end
      step();
      checks++;
      if (in_ready !== 1'b1 || uop_valid !== 1'b0 || uop_reg !== 6'd0 || uop_base !== 6'd0) begin
         failures++;
         $display("FAIL two_uops_idle got rdy=%b v=%b reg=%0d base=%0d required 1 0 0 0",
                  in_ready, uop_valid, uop_reg, uop_base);
      end
   endtask

   task automatic test_full_mask();
      uop_ready = 1'b1;
      offer(mk(OP_REGS, 16'hFFFF, 2'd0, 1'b1, 6'd5));
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (uop_valid !== 1'b1 || uop_reg !== 6'(i) || uop_ofs !== 16'(i * 8) ||
             uop_last !== (i == 15) || uop_load !== 1'b1 || uop_base !== 6'd5) begin
            failures++;
            $display("FAIL full_mask_uop%0d got v=%b reg=%0d ofs=%0d last=%b ld=%b base=%0d required 1 %0d %0d %b 1 5",
                     i, uop_valid, uop_reg, uop_ofs, uop_last, uop_load, uop_base, i, i * 8, (i == 15));
         end
         step();
      end
      checks++;
      if (uop_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_mask_end got v=%b rdy=%b required 0 1", uop_valid, in_ready);
      end
   endtask

   task automatic test_stall();
      uop_ready = 1'b0;
      offer(mk(OP_REGS, 16'h8001, 2'd0, 1'b1, 6'd2));
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (uop_valid !== 1'b1 || uop_reg !== 6'd0 || uop_ofs !== 16'd0 || uop_last !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold%0d got v=%b reg=%0d ofs=%0d last=%b required 1 0 0 0",
                     k, uop_valid, uop_reg, uop_ofs, uop_last);
         end
         step();
      end
      uop_ready = 1'b1;
      step();
      checks++;
      if (uop_valid !== 1'b1 || uop_reg !== 6'd15 || uop_ofs !== 16'd8 || uop_last !== 1'b1) begin
         failures++;
         $display("FAIL stall_second got v=%b reg=%0d ofs=%0d last=%b required 1 15 8 1",
                  uop_valid, uop_reg, uop_ofs, uop_last);
      end
      step();
      checks++;
      if (uop_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_end got v=%b rdy=%b required 0 1", uop_valid, in_ready);
      end
   endtask

   task automatic test_flush();
      uop_ready = 1'b1;
      offer(mk(OP_REGS, 16'h00F0, 2'd0, 1'b0, 6'd1));
      checks++;
      if (uop_valid !== 1'b1 || uop_reg !== 6'd4 || uop_ofs !== 16'd0) begin
         failures++;
         $display("FAIL flush_first got v=%b reg=%0d ofs=%0d required 1 4 0", uop_valid, uop_reg, uop_ofs);
      end
      step();
      checks++;
      if (uop_valid !== 1'b1 || uop_reg !== 6'd5 || uop_ofs !== 16'd8) begin
         failures++;
         $display("FAIL flush_second got v=%b reg=%0d ofs=%0d required 1 5 8", uop_valid, uop_reg, uop_ofs);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (uop_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_after%0d got v=%b rdy=%b reg=%0d required 0 1", k, uop_valid, in_ready, uop_reg);
         end
         step();
      end
   endtask

   task automatic test_ignored();
      uop_ready = 1'b1;
      offer(mk(OP_REGS, 16'h0000, 2'd3, 1'b1, 6'd9));
      checks++;
      if (in_ready !== 1'b1 || uop_valid !== 1'b0) begin
         failures++;
         $display("FAIL zero_mask got rdy=%b v=%b required 1 0", in_ready, uop_valid);
      end
      offer(mk(7'h13, 16'h0003, 2'd0, 1'b0, 6'd4));
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (in_ready !== 1'b1 || uop_valid !== 1'b0) begin
            failures++;
            $display("FAIL non_regs%0d got rdy=%b v=%b required 1 0", k, in_ready, uop_valid);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      uop_ready = 1'b1;
      offer(mk(OP_REGS, 16'h0F00, 2'd2, 1'b1, 6'd7));
      checks++;
      if (uop_valid !== 1'b1 || uop_reg !== 6'd40 || uop_load !== 1'b1 || uop_base !== 6'd7) begin
         failures++;
         $display("FAIL rst_mid_first got v=%b reg=%0d ld=%b base=%0d required 1 40 1 7",
                  uop_valid, uop_reg, uop_load, uop_base);
      end
      step();
      checks++;
      if (uop_reg !== 6'd41 || uop_ofs !== 16'd8) begin
         failures++;
         $display("FAIL rst_mid_second got reg=%0d ofs=%0d required 41 8", uop_reg, uop_ofs);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (uop_valid !== 1'b0 || uop_reg !== 6'd0 || uop_load !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_async got v=%b reg=%0d ld=%b required 0 0 0", uop_valid, uop_reg, uop_load);
      end
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (uop_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_after%0d got v=%b rdy=%b required 0 1", k, uop_valid, in_ready);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_two_uops();
      test_full_mask();
      test_stall();
      test_flush();
      test_ignored();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
